// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline stage register with a two-entry skid buffer,
// flush with control zeroing, optional bubble control gating and a saturating stall counter.
module pipe_skid_reg #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 2,
    parameter bit CTRL_GATE = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              acc, dep, main_load_in, main_load_skid, skid_load;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = (CTRL_GATE && !main_valid_q) ? '0 : main_ctrl_q;
    assign occ_o       = {skid_valid_q, main_valid_q & !skid_valid_q};
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        acc            = in_valid_i & in_ready_o;
        dep            = main_valid_q & out_ready_i;
        main_load_skid = !flush_i & skid_valid_q & dep;
        main_load_in   = !flush_i & acc & (!main_valid_q | dep);
        skid_load      = !flush_i & acc & main_valid_q & !dep;
        main_valid_d   = flush_i ? 1'b0 : main_valid_q ? (!dep | acc | skid_valid_q) : acc;
        skid_valid_d   = flush_i ? 1'b0 : skid_valid_q ? !dep : skid_load;
        main_data_d    = main_load_skid ? skid_data_q : main_load_in ? in_data_i : main_data_q;
        skid_data_d    = skid_load ? in_data_i : skid_data_q;
        main_ctrl_d    = flush_i ? '0 : main_load_skid ? skid_ctrl_q : main_load_in ? in_ctrl_i : main_ctrl_q;
        skid_ctrl_d    = flush_i ? '0 : skid_load ? in_ctrl_i : skid_ctrl_q;
        // Counts every stalled edge, flush or not; only reset clears it
        stall_cnt_d    = (main_valid_q & !out_ready_i & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            skid_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_ctrl_q  <= skid_ctrl_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised, elastic successor to the fixed-field stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic control bundle and a generic data bundle across one stage using a valid/ready handshake. A two-entry skid buffer lets the downstream stage stall without a combinational ready path back to the upstream stage. It also provides flush (bubble insertion) with control-field zeroing, and a saturating stall counter for performance debug.

Parameters:
DATA_W, 32, width of the data bundle (ALU result, memory data, addresses concatenated by the instantiating stage)
CTRL_W, 2, width of the control bundle (e.g. RegWrite, MemtoReg)
CTRL_GATE, 1, 1 = out_ctrl_o forced to 0 whenever out_valid_o=0; 0 = raw registered control
CNT_W, 16, width of the stall counter

Ports:
clk_i  in  1  clock; all state updates on posedge
start_i  in  1  asynchronous active-low reset; 0 = reset
flush_i  in  1  synchronous flush; discards all held and incoming entries
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  block can accept an entry; registered
in_ctrl_i  in  CTRL_W  upstream control bundle
in_data_i  in  DATA_W  upstream data bundle
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream accepts entry
out_ctrl_o  out  CTRL_W  output control bundle
out_data_o  out  DATA_W  output data bundle
occ_o  out  2  number of held entries (0..2)
stall_cnt_o  out  CNT_W  saturating count of cycles with out_valid_o=1 and out_ready_i=0

Behaviour:
- Storage: main entry (drives the outputs) and skid entry, each with valid, ctrl and data fields.
- States, encoded by valid bits: EMPTY (occ 0), ONE (main only), FULL (main+skid). Skid valid without main valid is illegal and must never occur.
- Handshakes: acc = in_valid_i & in_ready_o; dep = out_valid_o & out_ready_i.
- in_ready_o = !skid_valid, registered. It is purely state-derived and never depends combinationally on out_ready_i.
- Transitions, applied at posedge when flush_i=0:
  - EMPTY, acc -> ONE; main loads input.
  - ONE, acc & dep -> ONE; main loads input.
  - ONE, acc & !dep -> FULL; skid loads input, main holds.
  - ONE, !acc & dep -> EMPTY.
  - ONE, idle -> ONE; hold.
  - FULL, dep -> ONE; main loads skid; in_ready_o returns to 1 the next cycle.
  - FULL, !dep -> FULL; hold. acc is impossible in FULL because in_ready_o=0.
- Latency: an entry accepted at edge k is visible on out_* after edge k (1 cycle) if the block was EMPTY, or if it was ONE with dep at edge k.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush.
- Data and ctrl of a held entry are stable while out_valid_o=1 and out_ready_i=0.
- Flush (flush_i=1 at posedge): highest priority.
  - Both valids cleared; occ_o=0; in_ready_o=1 next cycle.
  - Same-cycle input is dropped, even if in_valid_i=1.
  - Same-cycle dep is ignored: the entry is not counted as delivered.
  - Stored ctrl fields cleared to 0; data fields retain their values.
- Control gating: with CTRL_GATE=1, out_ctrl_o = main_ctrl when main valid, else 0. This guarantees no RegWrite-type side effect from a bubble.
- Stall counter:
  - Increments by 1 at each posedge where out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush; cleared only by reset.
- Reset (start_i=0, asynchronous):
  - Outputs: out_valid_o=0, in_ready_o=1, out_ctrl_o=0, out_data_o=0, occ_o=0, stall_cnt_o=0.
  - Internal: all valid, ctrl and data fields cleared.
  - Deassertion mid-operation restarts from EMPTY; no pre-reset entry survives.

Test Plan:
- Streaming: out_ready_i=1; push D=0x11,0x22,0x33 with ctrl=2'b11 on consecutive cycles -> same values appear on out_* one cycle later, consecutive; occ_o stays 1; stall_cnt_o=0.
- Skid fill: out_ready_i=0; push 0xA, then 0xB -> after 2nd edge occ_o=2 and in_ready_o=0; 3rd push held on inputs is not accepted; raise out_ready_i -> outputs 0xA, 0xB, then the held 3rd value, in order; stall_cnt_o equals the stalled cycle count.
- Flush: block FULL with ctrl=2'b11, in_valid_i=1, flush_i=1 for 1 cycle -> next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0, in_ready_o=1; flushed input never appears on out_*.
- Simultaneous in/out in ONE: main=0x5, push 0x6 with out_ready_i=1 -> next cycle out_data_o=0x6, occ_o=1.
- Saturation: CNT_W=4; hold out_valid_o=1, out_ready_i=0 for 20 cycles -> stall_cnt_o=15 and stays 15.
- Async reset mid-FULL: pulse start_i low between edges -> outputs go to reset values immediately without a clock edge; after release the first pushed entry appears after 1 cycle.
